// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side push bus and issue-side pop bus of the instruction queue.
`default_nettype none

interface inst_queue_if #(
  parameter int DEPTH   = 8,
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2
);
  logic                             flush;
  logic                             in_valid;
  logic                             in_ready;
  logic [31:0]                      in_pc;
  logic [FETCH_N*32-1:0]            in_inst;
  logic [FETCH_N-1:0]               in_mask;
  logic [ISSUE_N-1:0]               out_valid;
  logic [ISSUE_N*32-1:0]            out_pc;
  logic [ISSUE_N*32-1:0]            out_inst;
  logic [$clog2(ISSUE_N+1)-1:0]     out_pop;
  logic [$clog2(DEPTH+1)-1:0]       count;

  modport master (
    output flush, in_valid, in_pc, in_inst, in_mask, out_pop,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_mask, out_pop,
    output in_ready, out_valid, out_pc, out_inst, count
  );
endinterface

`default_nettype wire

// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer taking masked fetch groups and presenting
// up to ISSUE_N head entries per cycle, with flush and clamped multi-pop.
`default_nettype none

module inst_queue #(
  parameter int DEPTH   = 8,
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2
) (
  input  wire logic   clk,
  input  wire logic   resetn,
  inst_queue_if.slave q
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
  localparam int POPW = $clog2(ISSUE_N+1);

  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_in_ready;
  logic          w_push;
  logic [CW-1:0] w_push_cnt;
  logic [CW-1:0] w_pushed;
  logic [CW-1:0] w_pop_req;
  logic [CW-1:0] w_pop;
  logic [PW-1:0] w_slot_idx [FETCH_N];
  logic          w_we       [DEPTH];
  logic [63:0]   w_wdata    [DEPTH];

  assign w_in_ready = (r_count <= CW'(DEPTH - FETCH_N));
  assign w_push     = q.in_valid && w_in_ready && !q.flush;
  assign q.in_ready = w_in_ready;
  assign q.count    = r_count;

  // Kept slots are packed: slot i lands at tail + (number of kept slots below i).
  always_comb begin
    w_push_cnt = '0;
    for (int i = 0; i < FETCH_N; i++) begin
      w_slot_idx[i] = r_tail + w_push_cnt[PW-1:0];
      w_push_cnt    = w_push_cnt + CW'(q.in_mask[i]);
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_we[e]    = 1'b0;
      w_wdata[e] = '0;
      for (int i = 0; i < FETCH_N; i++) begin
        if (w_push && q.in_mask[i] && (w_slot_idx[i] == PW'(e))) begin
          w_we[e]    = 1'b1;
          w_wdata[e] = {q.in_pc + 32'(4*i), q.in_inst[32*i +: 32]};
        end
      end
    end
  end

  assign w_pushed  = w_push ? w_push_cnt : '0;
  assign w_pop_req = CW'(q.out_pop);
  assign w_pop     = (w_pop_req > r_count) ? r_count : w_pop_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (q.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_pop[PW-1:0];
      r_tail  <= r_tail + w_pushed[PW-1:0];
      r_count <= r_count + w_pushed - w_pop;
    end
  end

  // Storage is intentionally left out of reset; validity is tracked by r_count alone.
  for (genvar e = 0; e < DEPTH; e++) begin : g_mem
    always_ff @(posedge clk) begin
      if (w_we[e]) begin
        r_mem[e] <= w_wdata[e];
      end
    end
  end

  for (genvar k = 0; k < ISSUE_N; k++) begin : g_out
    logic [PW-1:0] w_rd;
    assign w_rd                  = r_head + PW'(k);
    assign q.out_valid[k]        = (r_count > CW'(k));
    assign q.out_pc[32*k +: 32]   = r_mem[w_rd][63:32];
    assign q.out_inst[32*k +: 32] = r_mem[w_rd][31:0];
  end

  logic [POPW-1:0] w_unused_pop_width;
  assign w_unused_pop_width = q.out_pop;

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed scenarios plus randomized traffic checked against a queue model.
`default_nettype none

module tb_inst_queue;
  localparam int DEPTH   = 8;
  localparam int FETCH_N = 2;
  localparam int ISSUE_N = 2;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;
  logic [63:0] mq[$];

  inst_queue_if #(.DEPTH(DEPTH), .FETCH_N(FETCH_N), .ISSUE_N(ISSUE_N)) bus ();

  inst_queue #(.DEPTH(DEPTH), .FETCH_N(FETCH_N), .ISSUE_N(ISSUE_N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model queue (front = head entry).
  task automatic check_model();
    int cnt;
    cnt = mq.size();
    chk("count", 64'(bus.count), 64'(cnt));
    chk("in_ready", 64'(bus.in_ready), 64'((DEPTH - cnt) >= FETCH_N));
    for (int k = 0; k < ISSUE_N; k++) begin
      chk($sformatf("out_valid[%0d]", k), 64'(bus.out_valid[k]), 64'(cnt > k));
      if (k < cnt) begin
        chk($sformatf("out_pc[%0d]", k), 64'(bus.out_pc[32*k +: 32]), 64'(mq[k][63:32]));
        chk($sformatf("out_inst[%0d]", k), 64'(bus.out_inst[32*k +: 32]), 64'(mq[k][31:0]));
      end
    end
  endtask

  // Apply one cycle of inputs (called at negedge), advance the model, check after the edge.
  task automatic step(input logic fl, input logic vl, input logic [31:0] pc,
                      input logic [FETCH_N*32-1:0] inst, input logic [FETCH_N-1:0] mask,
                      input int pop);
    int cnt;
    int popc;
    bit rdy;
    bus.flush    = fl;
    bus.in_valid = vl;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
    bus.in_mask  = mask;
    bus.out_pop  = 2'(pop);
    cnt  = mq.size();
    rdy  = (DEPTH - cnt) >= FETCH_N;
    if (fl) begin
      mq.delete();
    end else begin
      popc = (pop < cnt) ? pop : cnt;
      repeat (popc) void'(mq.pop_front());
      if (vl && rdy) begin
        for (int i = 0; i < FETCH_N; i++) begin
          if (mask[i]) mq.push_back({pc + 32'(4*i), inst[32*i +: 32]});
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pc    = '0;
    bus.in_inst  = '0;
    bus.in_mask  = '0;
    bus.out_pop  = '0;
  endtask

  // Reset pulse asserted between clock edges; outputs must clear without waiting for clk.
  task automatic async_reset();
    idle_inputs();
    #2 resetn = 1'b0;
    #1;
    chk("async_rst out_valid", 64'(bus.out_valid), 64'(0));
    chk("async_rst count", 64'(bus.count), 64'(0));
    chk("async_rst in_ready", 64'(bus.in_ready), 64'(1));
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
    check_model();
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("reset out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset in_ready", 64'(bus.in_ready), 64'(1));
    check_model();
    resetn = 1'b1;

    // Full two-slot group
    step(0, 1, 32'h1000, {32'h2, 32'h1}, 2'b11, 0);
    chk("g1 out_valid", 64'(bus.out_valid), 64'h3);
    chk("g1 out_pc0", 64'(bus.out_pc[31:0]), 64'h1000);
    chk("g1 out_pc1", 64'(bus.out_pc[63:32]), 64'h1004);
    chk("g1 inst1", 64'(bus.out_inst[63:32]), 64'h2);
    chk("g1 count", 64'(bus.count), 64'd2);

    // Only upper slot kept: compacts into head with pc+4
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h2000, {32'hBBBB, 32'hAAAA}, 2'b10, 0);
    chk("g2 out_valid", 64'(bus.out_valid), 64'h1);
    chk("g2 out_pc0", 64'(bus.out_pc[31:0]), 64'h2004);
    chk("g2 out_inst0", 64'(bus.out_inst[31:0]), 64'hBBBB);

    // Over-pop clamps to occupancy
    step(0, 0, 0, 0, 0, 2);
    chk("clamp count", 64'(bus.count), 64'd0);
    chk("clamp out_valid", 64'(bus.out_valid), 64'h0);

    // Fill to 7, wrapping the tail
    step(0, 1, 32'h4000, {32'h11, 32'h10}, 2'b11, 0);
    step(0, 1, 32'h4008, {32'h13, 32'h12}, 2'b11, 0);
    step(0, 1, 32'h4010, {32'h15, 32'h14}, 2'b11, 0);
    step(0, 1, 32'h4018, {32'h17, 32'h16}, 2'b01, 0);
    chk("full count", 64'(bus.count), 64'd7);
    chk("full in_ready", 64'(bus.in_ready), 64'd0);
    step(0, 1, 32'h5000, {32'h99, 32'h98}, 2'b11, 0);
    chk("blocked count", 64'(bus.count), 64'd7);
    step(0, 0, 0, 0, 0, 2);
    chk("pop2 count", 64'(bus.count), 64'd5);
    chk("pop2 in_ready", 64'(bus.in_ready), 64'd1);
    step(0, 1, 32'h6000, {32'h21, 32'h20}, 2'b11, 2);
    chk("pushpop count", 64'(bus.count), 64'd5);
    step(0, 1, 32'h6008, {32'h23, 32'h22}, 2'b11, 1);
    chk("six count", 64'(bus.count), 64'd6);

    // Flush beats simultaneous push and pop
    step(1, 1, 32'h7000, {32'h31, 32'h30}, 2'b11, 2);
    chk("flush count", 64'(bus.count), 64'd0);
    chk("flush out_valid", 64'(bus.out_valid), 64'h0);
    chk("flush in_ready", 64'(bus.in_ready), 64'd1);

    // Mid-stream async reset, then first push lands at entry 0
    step(0, 1, 32'h8000, {32'h41, 32'h40}, 2'b11, 0);
    step(0, 1, 32'h8008, {32'h43, 32'h42}, 2'b11, 0);
    chk("pre_rst count", 64'(bus.count), 64'd4);
    async_reset();
    step(0, 1, 32'h3000, {32'h51, 32'h50}, 2'b01, 0);
    chk("post_rst out_pc0", 64'(bus.out_pc[31:0]), 64'h3000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 24) == 0,
             $urandom_range(0, 9) < 7,
             $urandom,
             {$urandom, $urandom},
             2'($urandom_range(0, 3)),
             int'($urandom_range(0, ISSUE_N)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, 8: entry count; a power of two, and at least 2*FETCH_N.
REQ-002 SHALL have parameter FETCH_N, 2: instruction slots offered per push.
REQ-003 SHALL have parameter ISSUE_N, 2: instruction slots presented per cycle; ISSUE_N <= DEPTH.
REQ-004 SHALL have one clock; reset is asynchronous and active-low. Ports are clk and resetn.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  redirect (branch taken); discards all queue contents.
REQ-008 in_valid  input  1  fetch group offered.
REQ-009 in_ready  output  1  queue can accept a full group.
REQ-010 in_pc  input  32  pc of slot 0 of the group.
REQ-011 in_inst  input  FETCH_N*32  slot i in bits [32i+31:32i].
REQ-012 in_mask  input  FETCH_N  per-slot keep bit.
REQ-013 out_valid  output  ISSUE_N  slot k holds a queued instruction.
REQ-014 out_pc  output  ISSUE_N*32  pc of each presented slot.
REQ-015 out_inst  output  ISSUE_N*32  instruction of each presented slot.
REQ-016 out_pop  input  clog2(ISSUE_N+1)  number of head entries consumed this cycle.
REQ-017 count  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-018 SHALL store each entry as {pc[31:0], inst[31:0]} in a circular buffer with head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-019 SHALL drive in_ready = (DEPTH - count >= FETCH_N), combinationally from registered count only.
REQ-020 SHALL push when in_valid && in_ready && !flush.
REQ-021 SHALL, on a push, write only slots with in_mask[i]=1, compacted in ascending i order starting at tail.
REQ-022 SHALL give slot i the pc value in_pc + 4*i, with 32-bit wrap.
REQ-023 SHALL advance tail on a push by popcount(in_mask); in_mask=0 SHALL push nothing.
REQ-024 SHALL drive out_valid[k] = (count > k), so valid slots are contiguous from k=0.
REQ-025 SHALL drive out slot k from entry (head+k) mod DEPTH, read combinationally from storage.
REQ-026 SHALL make a pushed entry visible on the outputs the cycle after the push (latency 1); there is no bypass.
REQ-027 SHALL clamp the pop amount to min(out_pop, count) and advance head by the clamped amount.
REQ-028 SHALL allow a push and a pop in the same cycle: count_next = count + pushed - popped_clamped.
REQ-029 SHALL evaluate in_ready and pop availability against the pre-cycle count; a same-cycle pop does not raise capacity for that cycle's push.
REQ-030 SHALL, when flush=1, set head=tail=0 and count=0 at the next edge, ignoring that cycle's push and pop.
REQ-031 SHALL treat flush as having priority over all other events.
REQ-032 SHALL never let count exceed DEPTH or drop below 0 under any input sequence.

Reset
REQ-033 SHALL, while resetn=0, asynchronously force head=0, tail=0, count=0; hence out_valid=0 and in_ready=1.
REQ-034 Storage contents SHALL NOT be reset; out_pc and out_inst are don't-care while the matching out_valid=0.
REQ-035 SHALL discard all contents when reset is asserted mid-operation; the first post-reset push lands at entry 0.

Verification
REQ-036 Push pc=0x1000, inst={0x2,0x1}, mask=11 -> next cycle out_valid=11, out_pc={0x1004,0x1000}, count=2.
REQ-037 Push pc=0x2000, mask=10 -> one entry written with pc=0x2004; out_valid=01 next cycle.
REQ-038 Fill to count=7 (DEPTH=8) -> in_ready=0; pop 2 -> count=5, in_ready=1; then push 2 and pop 2 in the same cycle -> count stays 5 and head/tail wrap correctly.
REQ-039 count=1, out_pop=2 -> head advances by 1, count=0, out_valid=00.
REQ-040 count=6 with flush, in_valid and out_pop=2 all high -> next cycle count=0, out_valid=00, in_ready=1, nothing pushed.
REQ-041 Assert resetn=0 asynchronously mid-stream with count=4 -> out_valid=00 immediately; after release, push pc=0x3000 -> out_pc[31:0]=0x3000 next cycle.
